// File: rtl/modacc.sv
// Modular accumulator: sums len reduced products mod q, then presents the sum on a valid/ready handshake.
// Optional input register stage enabled by defining MODACC_IN_REG_EN (adds one cycle of latency).
module modacc #(
  parameter int data_width_p = 64,
  parameter int len_width_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [len_width_p-1:0]  len_i,
  input  logic [data_width_p-1:0] mod_i,
  input  logic                    valid_i,
  input  logic [data_width_p-1:0] res_i,
  output logic                    busy_o,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output logic [data_width_p-1:0] sum_o,
  output logic [len_width_p-1:0]  count_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                  state_q;
  logic [data_width_p-1:0] acc_q;
  logic [data_width_p-1:0] q_q;
  logic [len_width_p-1:0]  len_q;
  logic                    acc_vld;
  logic [data_width_p-1:0] acc_res;

`ifdef MODACC_IN_REG_EN
  logic                    in_vld_q;
  logic [data_width_p-1:0] in_res_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      in_res_q <= '0;
    end else begin
      in_vld_q <= valid_i;
      in_res_q <= res_i;
    end
  end

  assign acc_vld = in_vld_q;
  assign acc_res = in_res_q;
`else
  assign acc_vld = valid_i;
  assign acc_res = res_i;
`endif

  // One extra bit keeps the carry so a single conditional subtract is exact.
  logic [data_width_p:0]   sum_ext;
  logic [data_width_p-1:0] diff;
  logic [data_width_p-1:0] acc_nxt;
  logic [len_width_p-1:0]  count_nxt;

  assign sum_ext   = {1'b0, acc_q} + {1'b0, acc_res};
  assign diff      = sum_ext[data_width_p-1:0] - q_q;
  assign acc_nxt   = (sum_ext >= {1'b0, q_q}) ? diff : sum_ext[data_width_p-1:0];
  assign count_nxt = count_o + {{(len_width_p-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      q_q          <= '0;
      len_q        <= '0;
      count_o      <= '0;
      err_o        <= 1'b0;
      done_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      sum_o        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_vld) err_o <= 1'b1;
          if (start_i) begin
            len_q   <= len_i;
            q_q     <= mod_i;
            acc_q   <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            if (len_i == '0) begin
              state_q      <= OUT;
              done_valid_o <= 1'b1;
              sum_o        <= '0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (acc_vld) begin
            acc_q   <= acc_nxt;
            count_o <= count_nxt;
            if (count_nxt == len_q) begin
              state_q      <= OUT;
              done_valid_o <= 1'b1;
              sum_o        <= acc_nxt;
            end
          end
        end
        OUT: begin
          if (acc_vld) err_o <= 1'b1;
          if (done_ready_i) begin
            state_q      <= IDLE;
            done_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            sum_o        <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modacc.sv
// Scoreboard bench for modacc: stimulus queues expected results, a negedge monitor checks them.
module tb_modacc;

`ifdef MODACC_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] len_i;
  logic [63:0] mod_i;
  logic        valid_i;
  logic [63:0] res_i;
  logic        busy_o;
  logic        done_valid_o;
  logic        done_ready_i;
  logic [63:0] sum_o;
  logic [15:0] count_o;
  logic        err_o;

  modacc dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .mod_i(mod_i),
    .valid_i(valid_i), .res_i(res_i), .busy_o(busy_o), .done_valid_o(done_valid_o),
    .done_ready_i(done_ready_i), .sum_o(sum_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] sum;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   prev_dv  = 0;
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops on each new done_valid_o, then checks the output holds until handshake.
  always @(negedge clk_i) begin
    if (rst_n && done_valid_o) begin
      if (!prev_dv) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: sum %0h count %0d with empty scoreboard", sum_o, count_o);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          chk("sum", sum_o, cur.sum);
          chk("count", {48'd0, count_o}, {48'd0, cur.cnt});
          chk("latency_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end else if (have_cur) begin
        chk("sum_hold", sum_o, cur.sum);
        chk("count_hold", {48'd0, count_o}, {48'd0, cur.cnt});
      end
    end
    prev_dv = rst_n && done_valid_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [63:0] q, input logic [15:0] len);
    start_i = 1'b1; mod_i = q; len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic prod(input logic [63:0] r, input bit last, input logic [63:0] s, input logic [15:0] c);
    valid_i = 1'b1; res_i = r;
    if (last) exp_q.push_back('{s, c, cyc + LAT});
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy_o; i++) tick();
    chk("idle_reached", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_done_valid"}, {63'd0, done_valid_o}, 64'd0);
    chk({tag, "_sum"}, sum_o, 64'd0);
    chk({tag, "_count"}, {48'd0, count_o}, 64'd0);
    chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
  endtask

  localparam logic [63:0] BIGQ = 64'hFFFF_FFFF_FFFF_FFC5;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; len_i = '0; mod_i = '0;
    valid_i = 1'b0; res_i = '0; done_ready_i = 1'b1;
    repeat (3) tick();
    chk_cleared("reset");
    rst_n = 1'b1;

    // 5+9+10 mod 17 = 7
    start_run(64'd17, 16'd3);
    chk("busy_in_acc", {63'd0, busy_o}, 64'd1);
    prod(64'd5, 0, 0, 0);
    prod(64'd9, 0, 0, 0);
    prod(64'd10, 1, 64'd7, 16'd3);
    wait_idle();
    chk("err_clean_run", {63'd0, err_o}, 64'd0);

    // (q-1)+(q-1) overflows 64 bits; result q-2
    start_run(BIGQ, 16'd2);
    prod(BIGQ - 64'd1, 0, 0, 0);
    prod(BIGQ - 64'd1, 1, BIGQ - 64'd2, 16'd2);
    wait_idle();

    // len=0 goes straight to OUT; stray valid and start in OUT are ignored but flag err
    done_ready_i = 1'b0;
    exp_q.push_back('{64'd0, 16'd0, cyc + 1});
    start_run(64'd17, 16'd0);
    start_i = 1'b1; len_i = 16'd5; valid_i = 1'b1; res_i = 64'd4;
    tick();
    start_i = 1'b0; valid_i = 1'b0;
    tick();
    tick();
    chk("err_from_out", {63'd0, err_o}, 64'd1);
    chk("sum_zero_len0", sum_o, 64'd0);
    chk("busy_out_len0", {63'd0, busy_o}, 64'd1);
    done_ready_i = 1'b1;
    wait_idle();
    chk("err_sticky_idle", {63'd0, err_o}, 64'd1);

    // gapped products, consumer stalls 5 cycles
    done_ready_i = 1'b0;
    start_run(64'd17, 16'd2);
    chk("err_cleared_by_start", {63'd0, err_o}, 64'd0);
    prod(64'd3, 0, 0, 0);
    repeat (4) tick();
    prod(64'd4, 1, 64'd7, 16'd2);
    repeat (5) tick();
    chk("held_done_valid", {63'd0, done_valid_o}, 64'd1);
    done_ready_i = 1'b1;
    wait_idle();
    chk("dv_after_hs", {63'd0, done_valid_o}, 64'd0);
    chk("sum_after_hs", sum_o, 64'd0);

    // reset in mid-run, then an immediate new run
    start_run(64'd17, 16'd3);
    prod(64'd7, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    chk_cleared("midrun_reset");
    rst_n = 1'b1;
    start_run(64'd17, 16'd1);
    prod(64'd16, 1, 64'd16, 16'd1);
    wait_idle();

    // out-of-contract res >= q: single subtract, no flag
    start_run(64'd17, 16'd1);
    prod(64'd20, 1, 64'd3, 16'd1);
    wait_idle();
    chk("err_res_ge_q", {63'd0, err_o}, 64'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
